// File: rtl/my_alu_pkg.sv
// Shared ALU definitions: default operand width, divider FSM states and
// the constants the sequential divider relies on.
package my_alu_pkg;

    localparam int unsigned DivW    = 8;
    localparam int unsigned DivCntW = $clog2(DivW);

    // Quotient reported for a zero divisor: all ones over W bits, zero-extended.
    localparam logic [DivW:0] DivZeroQuot = {1'b0, {DivW{1'b1}}};

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } div_state_e;

endpackage

// File: rtl/my_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module my_div_step #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] r_i,
    input  logic         q_msb_i,
    input  logic [W-1:0] d_i,
    output logic [W:0]   r_o,
    output logic         q_bit_o
);

    logic [W:0]   shifted;
    logic [W+1:0] trial;
    logic         borrow;

    always_comb begin
        shifted = {r_i, q_msb_i};
        // One extra bit on top catches the borrow of the trial subtraction.
        trial   = {1'b0, shifted} - {2'b00, d_i};
        borrow  = trial[W+1];
        q_bit_o = ~borrow;
        r_o     = borrow ? shifted : trial[W:0];
    end

endmodule

// File: rtl/my_div_seq.sv
// Multi-cycle unsigned restoring divider with valid/ready handshakes on the
// operand and result sides; one quotient bit per cycle.
module my_div_seq
    import my_alu_pkg::*;
#(
    parameter int unsigned W = DivW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   divisao,
    output logic [W:0]   resto,
    output logic         div_zero
);

    localparam int unsigned    CntW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(W - 1);

    div_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W:0]      r_q, r_d;
    logic [W-1:0]    q_q, q_d;
    logic [W-1:0]    d_q, d_d;
    logic            dz_q, dz_d;

    logic [W:0]      step_r;
    logic            step_qbit;

    // Remainder stays below the divisor, so its top bit never feeds the shift.
    my_div_step #(
        .W (W)
    ) u_step (
        .r_i     (r_q[W-1:0]),
        .q_msb_i (q_q[W-1]),
        .d_i     (d_q),
        .r_o     (step_r),
        .q_bit_o (step_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        dz_d    = dz_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    d_d = in2;
                    if (in2 != '0) begin
                        q_d     = in1;
                        r_d     = '0;
                        dz_d    = 1'b0;
                        cnt_d   = CntMax;
                        state_d = StCalc;
                    end else begin
                        q_d     = '1;
                        r_d     = {1'b0, in1};
                        dz_d    = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StCalc: begin
                r_d   = step_r;
                q_d   = {q_q[W-2:0], step_qbit};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign divisao   = {1'b0, q_q};
    assign resto     = r_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_my_div_seq.sv
// Self-checking bench for my_div_seq: scoreboard of reference results,
// latency, backpressure, mid-operation reset and back-to-back traffic.
module tb_my_div_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in1 = '0;
    logic [7:0] in2 = '0;
    logic       in_ready;
    logic       out_valid;
    logic [8:0] divisao;
    logic [8:0] resto;
    logic       div_zero;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [8:0] q;
        logic [8:0] r;
        logic       dz;
    } res_t;

    res_t exp_q[$];

    my_div_seq #(
        .W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .divisao   (divisao),
        .resto     (resto),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b);
        res_t m;
        if (b == 8'd0) begin
            m.q  = 9'h0FF;
            m.r  = {1'b0, a};
            m.dz = 1'b1;
        end else begin
            m.q  = {1'b0, a / b};
            m.r  = {1'b0, a % b};
            m.dz = 1'b0;
        end
        return m;
    endfunction

    // Drive one operand pair, push its reference result at the accept edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        int n;
        @(negedge clk);
        in1 = a;
        in2 = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL issue_ready got=%b want=1", in_ready);
        end
        @(posedge clk);
        exp_q.push_back(model(a, b));
        #1 in_valid = 1'b0;
    endtask

    // Cycle number (accept edge = cycle 0) at which out_valid is first seen.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        total++;
        if ({in_ready, out_valid, divisao, resto, div_zero} !== {1'b1, 1'b0, 9'd0, 9'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got rdy=%b vld=%b q=%0d r=%0d dz=%b want rdy=1 vld=0 q=0 r=0 dz=0",
                     in_ready, out_valid, divisao, resto, div_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int   lat;
        res_t e;
        out_ready = 1'b1;
        issue(8'd25, 8'd3);
        wait_out(lat);
        e = exp_q.pop_front();
        total++;
        if (out_valid !== 1'b1 || lat != 9) begin
            bad++;
            $display("FAIL basic_latency got vld=%b cycle=%0d want vld=1 cycle=9", out_valid, lat);
        end
        total++;
        if ({divisao, resto, div_zero} !== {9'd8, 9'd1, 1'b0} || e.q != 9'd8) begin
            bad++;
            $display("FAIL basic_result got q=%0d r=%0d dz=%b want q=8 r=1 dz=0",
                     divisao, resto, div_zero);
        end
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_table;
        logic [7:0] as [4] = '{8'd255, 8'd0, 8'd6, 8'd200};
        logic [7:0] bs [4] = '{8'd1, 8'd7, 8'd7, 8'd200};
        int   lat;
        res_t e;
        for (int i = 0; i < 4; i++) begin
            issue(as[i], bs[i]);
            wait_out(lat);
            e = exp_q.pop_front();
            total++;
            if (out_valid !== 1'b1 || lat != 9 ||
                {divisao, resto, div_zero} !== {e.q, e.r, e.dz}) begin
                bad++;
                $display("FAIL table_%0d got q=%0d r=%0d dz=%b cycle=%0d want q=%0d r=%0d dz=%b cycle=9",
                         i, divisao, resto, div_zero, lat, e.q, e.r, e.dz);
            end
            total++;
            if ((32'(divisao) * 32'(bs[i]) + 32'(resto)) != 32'(as[i]) || resto >= {1'b0, bs[i]}) begin
                bad++;
                $display("FAIL invariant_%0d got q=%0d r=%0d want q*%0d+r=%0d and r<%0d",
                         i, divisao, resto, bs[i], as[i], bs[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_div_zero;
        int   lat;
        res_t e;
        issue(8'd7, 8'd0);
        wait_out(lat);
        e = exp_q.pop_front();
        total++;
        if (out_valid !== 1'b1 || lat != 1) begin
            bad++;
            $display("FAIL dz_latency got vld=%b cycle=%0d want vld=1 cycle=1", out_valid, lat);
        end
        total++;
        if ({divisao, resto, div_zero} !== {9'h0FF, 9'd7, 1'b1} || e.dz !== 1'b1) begin
            bad++;
            $display("FAIL dz_result got q=%h r=%0d dz=%b want q=0ff r=7 dz=1", divisao, resto, div_zero);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure;
        int   lat;
        res_t e;
        out_ready = 1'b0;
        issue(8'd50, 8'd6);
        wait_out(lat);
        e = exp_q[0];
        in1 = 8'd9;
        in2 = 8'd4;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {divisao, resto, div_zero} !== {e.q, e.r, e.dz}) begin
                bad++;
                $display("FAIL bp_hold_%0d got vld=%b rdy=%b q=%0d r=%0d dz=%b want vld=1 rdy=0 q=%0d r=%0d dz=%b",
                         i, out_valid, in_ready, divisao, resto, div_zero, e.q, e.r, e.dz);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
        @(posedge clk);
        exp_q.push_back(model(8'd9, 8'd4));
        #1 in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_new_accept got rdy=%b want rdy=0", in_ready);
        end
        wait_out(lat);
        e = exp_q.pop_front();
        total++;
        if (out_valid !== 1'b1 || lat != 9 || {divisao, resto, div_zero} !== {e.q, e.r, e.dz}) begin
            bad++;
            $display("FAIL bp_new_result got q=%0d r=%0d dz=%b cycle=%0d want q=%0d r=%0d dz=%b cycle=9",
                     divisao, resto, div_zero, lat, e.q, e.r, e.dz);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        int   lat;
        res_t e;
        logic seen;
        issue(8'd100, 8'd9);
        e = exp_q.pop_back();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, divisao, resto, div_zero} !== {1'b1, 1'b0, 9'd0, 9'd0, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset got rdy=%b vld=%b q=%0d r=%0d dz=%b want rdy=1 vld=0 q=0 r=0 dz=0",
                     in_ready, out_valid, divisao, resto, div_zero);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL mid_reset_idle got stray activity=1 want 0");
        end
        issue(8'd100, 8'd9);
        wait_out(lat);
        e = exp_q.pop_front();
        total++;
        if (out_valid !== 1'b1 || lat != 9 || {divisao, resto, div_zero} !== {9'd11, 9'd1, 1'b0} ||
            e.q != 9'd11) begin
            bad++;
            $display("FAIL mid_reset_rerun got q=%0d r=%0d dz=%b cycle=%0d want q=11 r=1 dz=0 cycle=9",
                     divisao, resto, div_zero, lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int got;
        int cyc;
        res_t e;
        out_ready = 1'b1;
        got = 0;
        cyc = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    logic [7:0] a;
                    logic [7:0] b;
                    int n;
                    a = 8'($urandom_range(0, 255));
                    b = (i == 3) ? 8'd0 : 8'($urandom_range(0, 255));
                    in1 = a;
                    in2 = b;
                    in_valid = 1'b1;
                    n = 0;
                    @(negedge clk);
                    while (!in_ready && n < 50) begin
                        @(negedge clk);
                        n++;
                    end
                    @(posedge clk);
                    exp_q.push_back(model(a, b));
                    #1;
                end
                in_valid = 1'b0;
            end
            begin
                while (got < 10 && cyc < 300) begin
                    @(negedge clk);
                    cyc++;
                    if (out_valid) begin
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL b2b_extra got result q=%0d r=%0d want none", divisao, resto);
                        end else begin
                            e = exp_q.pop_front();
                            if ({divisao, resto, div_zero} !== {e.q, e.r, e.dz}) begin
                                bad++;
                                $display("FAIL b2b_%0d got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                                         got, divisao, resto, div_zero, e.q, e.r, e.dz);
                            end
                        end
                        got++;
                    end
                end
            end
        join
        total++;
        if (got != 10 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_count got results=%0d pending=%0d want results=10 pending=0",
                     got, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_table();
        test_div_zero();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/my_div_seq.md
# my_div_seq

Multi-cycle restoring divider that answers the operand pairs issued by the ALU bench and top level (`in1`, `in2`). It returns quotient (`divisao`) and remainder (`resto`) in the same 9-bit result format as the other ALU results. A valid/ready handshake sits on both the operand side and the result side. It replaces the combinational division path where timing matters, and is the responder end of the operand-issue interface.

## Interface
- `W`, 8 — operand width; results are `W+1` bits.
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `in_valid` input 1 — the operand pair on `in1`/`in2` is valid.
- `in_ready` output 1 — block can accept operands; high only in IDLE.
- `in1` input W — dividend, unsigned.
- `in2` input W — divisor, unsigned.
- `out_valid` output 1 — the result is valid.
- `out_ready` input 1 — the consumer accepts the result.
- `divisao` output W+1 — quotient, zero-extended.
- `resto` output W+1 — remainder, zero-extended.
- `div_zero` output 1 — the result came from a divisor of 0.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. When `in_valid`, latch `in1` and `in2`. If `in2`≠0, go to CALC; if `in2`=0, go to DONE.
  - CALC: W iterations, counter runs W-1 down to 0. Each cycle computes trial = {R[W-1:0], Q[W-1]} − D.
    - No borrow: R ← trial, shift a 1 into Q.
    - Borrow: R ← {R[W-1:0], Q[W-1]}, shift a 0 into Q.
    - Q starts equal to the dividend; R (W+1 bits) starts at 0. Go to DONE after the iteration with count 0.
  - DONE: `out_valid`=1, with `divisao`={1'b0,Q}, `resto`=R, and `div_zero`. On `out_ready`, go to IDLE.
- Divide by zero: `divisao`=9'h0FF (all ones over W bits, zero-extended), `resto`={1'b0,in1}, `div_zero`=1. No CALC cycles are spent.
- Results are unsigned for all operand values. Invariant: in1 = divisao·in2 + resto, and resto < in2.
- Backpressure: while `out_valid` && !`out_ready`, all outputs are held bit-stable.
- `in_valid` outside IDLE is ignored; no operand is lost because `in_ready`=0.
- Reset (asynchronous, any state, including mid-CALC): state returns to IDLE. All outputs clear: `in_ready` becomes 1 as IDLE is entered; `out_valid`, `divisao`, `resto` and `div_zero` become 0. Any partial result is discarded; no result is emitted for the aborted operation.

## Timing
- Operand accept: the rising edge on which `in_valid` && `in_ready`. Call this cycle 0.
- Nonzero divisor: CALC occupies cycles 1..W. `out_valid` rises after the edge ending cycle W, so the result is visible in cycle W+1 (the 9th cycle for W=8).
- Zero divisor: `out_valid` is visible in cycle 1.
- Result accept: the edge where `out_valid` && `out_ready`. `in_ready` is 1 in the following cycle.
- Throughput: at best one division per W+2 cycles with `out_ready` tied high. No overlap between operations.
- `in_ready` and `out_valid` are registered state decodes. Neither depends combinationally on `in_valid` or `out_ready`.

## Structure
- Shared package `my_alu_pkg`:
  - default width `W`=8;
  - FSM state type (IDLE, CALC, DONE);
  - divide-by-zero quotient constant;
  - counter width $clog2(W).
- One natural sub-module, `my_div_step`. It is the combinational single iteration: inputs R, Q[W-1], D; outputs next R and the quotient bit. It is instantiated once inside `my_div_seq`.
- `my_div_seq` holds the FSM, counter, R/Q/D registers and handshake logic.

## Test plan
- 25 / 3 (the standard bench operands), `out_ready`=1 → `divisao`=8, `resto`=1, `div_zero`=0. `out_valid` appears exactly 9 cycles after accept.
- 255/1 → 255 rem 0; 0/7 → 0 rem 0; 6/7 → 0 rem 6; 200/200 → 1 rem 0. For all of them, check the invariant in1 = q·in2 + r.
- 7 / 0 → `div_zero`=1, `divisao`=9'h0FF, `resto`=7. `out_valid` appears 1 cycle after accept.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` rises; drive `in_valid`=1 with new operands meanwhile. Required: outputs stable, `in_ready`=0, new operands not taken. Then release `out_ready` → IDLE; the new pair is accepted on the next edge.
- Assert `rst_n`=0 asynchronously in CALC cycle 4 of 100/9 → all outputs 0 immediately and `in_ready`=1 after release. A following 100/9 gives 11 rem 1 with normal latency.
- Back-to-back: 10 random pairs with `in_valid` held high and `out_ready` high → each result matches the reference model, in order, with no drops or duplicates.
